// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter using reverse double-dabble.
// A captured BCD word is shifted right one bit per clock into a binary
// register. After each shift, every BCD nibble that is >= 8 has 3 subtracted.
// Words containing a non-decimal digit skip the conversion entirely. They
// complete with err set and an all-ones result.
module bcd_to_bin_serial #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam int unsigned CntW   = $clog2(BcdW + 1);
  localparam int unsigned MaxDec = 10 ** DIGITS - 1;
  localparam logic [CntW-1:0] LastStep = CntW'(BcdW - 1);

  // Refuse to elaborate an unsupported digit count or too narrow an output.
  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_to_bin_serial: DIGITS must be in 1..4");
  end
  if (BIN_W < 32 && (32'd1 << BIN_W) <= MaxDec) begin : g_bad_width
    $error("bcd_to_bin_serial: BIN_W too narrow for DIGITS");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   bin_q, bin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;
  logic              err_q, err_d;

  logic [BcdW-1:0]   bcd_shift, bcd_fix, bin_shift;
  logic [3:0]        nib;
  logic              digit_bad;

  // One reverse double-dabble step plus a check of the incoming digits.
  always_comb begin
    bcd_shift = bcd_q >> 1;
    bin_shift = {bcd_q[0], bin_q[BcdW-1:1]};
    bcd_fix   = '0;
    nib       = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = bcd_shift[4*i +: 4];
      if (nib >= 4'd8) nib = nib - 4'd3;
      bcd_fix[4*i +: 4] = nib;
    end
    digit_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
          if (digit_bad) begin
            state_d   = StDone;
            err_d     = 1'b1;
            bin_out_d = '1;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        bcd_d = bcd_fix;
        bin_d = bin_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          state_d   = StDone;
          // High bits are zero for decimal input, so truncation is lossless.
          bin_out_d = BIN_W'(bin_shift);
          err_d     = 1'b0;
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // out_valid follows DONE by one cycle and drops on the accepting edge.
    out_valid_d = (state_q == StDone) && !(out_valid_q && out_ready);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      bin_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      bin_out_q   <= bin_out_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Directed plus randomized bench for bcd_to_bin_serial (DIGITS=2, BIN_W=7).
module tb_bcd_to_bin_serial;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned BIN_W  = 7;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic [4*DIGITS-1:0] bcd_in   = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [BIN_W-1:0]   bin_out;
  logic               err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_to_bin_serial #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_in   (bcd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value of the digits, or error code for any digit > 9.
  task automatic ref_model(input logic [4*DIGITS-1:0] w, output logic [BIN_W-1:0] b,
                           output logic e);
    int v;
    logic [3:0] d;
    v = 0;
    e = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      d = w[4*i +: 4];
      if (d > 4'd9) e = 1'b1;
      v = v * 10 + int'(d);
    end
    b = e ? '1 : BIN_W'(v);
  endtask

  // Send one word, wait for the result, hold it under backpressure, then drain.
  task automatic xfer(input logic [4*DIGITS-1:0] w, input int hold);
    logic [BIN_W-1:0] eb;
    logic             ee;
    int               lat;
    int               bad;
    int               exp_lat;
    ref_model(w, eb, ee);
    exp_lat = ee ? 1 : 4 * int'(DIGITS) + 1;
    in_valid = 1'b1;
    bcd_in   = w;
    step();
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad++;
      in_valid = 1'($urandom);
      bcd_in   = 8'($urandom);
      step();
      lat++;
    end
    check($sformatf("latency %02h", w), 32'(lat), 32'(exp_lat));
    check($sformatf("bin_out %02h", w), 32'(bin_out), 32'(eb));
    check($sformatf("err %02h", w), 32'(err), 32'(ee));
    repeat (hold) begin
      in_valid = 1'($urandom);
      bcd_in   = 8'($urandom);
      step();
      if (!out_valid || bin_out !== eb || err !== ee || in_ready) bad++;
    end
    check($sformatf("busy/hold stable %02h", w), 32'(bad), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check($sformatf("drain out_valid %02h", w), 32'(out_valid), 32'd0);
    check($sformatf("drain in_ready %02h", w), 32'(in_ready), 32'd1);
    check($sformatf("drain bin_out kept %02h", w), 32'(bin_out), 32'(eb));
  endtask

  initial begin
    logic [4*DIGITS-1:0] w;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset bin_out", 32'(bin_out), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    xfer(8'h42, 0);
    xfer(8'h99, 0);
    xfer(8'h00, 0);
    xfer(8'h10, 0);
    xfer(8'h5A, 0);
    xfer(8'h07, 0);
    xfer(8'h63, 5);

    // Abort a conversion partway through the shift phase.
    in_valid = 1'b1;
    bcd_in   = 8'h88;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort bin_out", 32'(bin_out), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    xfer(8'h21, 0);

    // All decimal words with random idle gaps and backpressure.
    for (int t = 0; t < 100; t++) begin
      w[7:4] = 4'(t / 10);
      w[3:0] = 4'(t % 10);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      xfer(w, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
